// File: rtl/player_ctl_nsong_if.sv
// Key, generator-bank and display signals of the N-song player controller.
interface player_ctl_nsong_if #(
  parameter int NUM_SONGS = 4,
  parameter int PIX_W     = 16
);
  logic                       start;
  logic                       stop;
  logic                       next_song;
  logic                       pre_song;
  logic [NUM_SONGS-1:0]       song_done;
  logic [NUM_SONGS-1:0]       frq_in;
  logic [NUM_SONGS*PIX_W-1:0] pixel_data;
  logic [NUM_SONGS-1:0]       song_en;
  logic [NUM_SONGS-1:0]       song_restart;
  logic                       frq;
  logic [PIX_W-1:0]           o_pixel_data;
  logic                       start_stop;
  logic [3:0]                 o_hex_data;

  modport master (
    output start, stop, next_song, pre_song,
    output song_done, frq_in, pixel_data,
    input  song_en, song_restart, frq,
    input  o_pixel_data, start_stop, o_hex_data
  );

  modport slave (
    input  start, stop, next_song, pre_song,
    input  song_done, frq_in, pixel_data,
    output song_en, song_restart, frq,
    output o_pixel_data, start_stop, o_hex_data
  );
endinterface

// File: rtl/player_ctl_nsong.sv
// N-song player controller: play/pause/stop, next/prev navigation, output mux.
// Define AUTO_ADVANCE_EN to roll into the next song when a track ends.
module player_ctl_nsong #(
  parameter int NUM_SONGS = 4,
  parameter int SEL_W     = 2,
  parameter int PIX_W     = 16
) (
  input logic               clk,
  input logic               rst_n,
  player_ctl_nsong_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE,
    SWITCH
  } state_t;

  localparam logic [SEL_W-1:0] LAST =
    SEL_W'(NUM_SONGS - 1);
  localparam logic [NUM_SONGS-1:0] ONE =
    NUM_SONGS'(1);

  state_t               state, state_nx;
  logic [SEL_W-1:0]     idx, idx_nx;
  logic [SEL_W-1:0]     idx_up, idx_dn;
  logic [3:0]           keys, key_q, pulse;
  logic                 ev_stop, ev_start;
  logic                 ev_next, ev_pre, ev_done;
  logic [NUM_SONGS-1:0] en_q, rst_q;
  logic                 frq_q, ss_q;
  logic [PIX_W-1:0]     pix_q;

  assign keys = {bus.stop, bus.start,
                 bus.next_song, bus.pre_song};
  assign pulse = keys & ~key_q;

  // One winner per cycle: stop > start > next > pre > done.
  assign ev_stop  = pulse[3];
  assign ev_start = pulse[2] & ~pulse[3];
  assign ev_next  = pulse[1] & ~|pulse[3:2];
  assign ev_pre   = pulse[0] & ~|pulse[3:1];
  assign ev_done  = bus.song_done[idx] & ~|pulse;

  assign idx_up = (idx == LAST) ? '0 : idx + 1'b1;
  assign idx_dn = (idx == '0) ? LAST : idx - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
      state <= IDLE;
      idx   <= '0;
    end else begin
      key_q <= keys;
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        if (ev_start) begin
          state_nx = SWITCH;
        end else if (ev_next) begin
          idx_nx = idx_up;
        end else if (ev_pre) begin
          idx_nx = idx_dn;
        end
      end
      SWITCH: state_nx = PLAY;
      PLAY: begin
        if (ev_stop) begin
          state_nx = PAUSE;
        end else if (ev_next) begin
          idx_nx   = idx_up;
          state_nx = SWITCH;
        end else if (ev_pre) begin
          idx_nx   = idx_dn;
          state_nx = SWITCH;
        end else if (ev_done) begin
`ifdef AUTO_ADVANCE_EN
          idx_nx   = idx_up;
          state_nx = SWITCH;
`else
          state_nx = IDLE;
`endif
        end
      end
      PAUSE: begin
        if (ev_stop) begin
          state_nx = IDLE;
        end else if (ev_start) begin
          state_nx = PLAY;
        end else if (ev_next) begin
          idx_nx   = idx_up;
          state_nx = IDLE;
        end else if (ev_pre) begin
          idx_nx   = idx_dn;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Enables track the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= '0;
      rst_q <= '0;
      frq_q <= 1'b0;
      ss_q  <= 1'b0;
      pix_q <= '0;
    end else begin
      en_q  <= (state_nx == PLAY) ? (ONE << idx_nx) : '0;
      rst_q <= (state_nx == SWITCH) ? (ONE << idx_nx) : '0;
      frq_q <= (state == PLAY) & bus.frq_in[idx];
      ss_q  <= (state == PLAY);
      pix_q <= bus.pixel_data[int'(idx)*PIX_W +: PIX_W];
    end
  end

  assign bus.song_en      = en_q;
  assign bus.song_restart = rst_q;
  assign bus.frq          = frq_q;
  assign bus.start_stop   = ss_q;
  assign bus.o_pixel_data = pix_q;
  assign bus.o_hex_data   = 4'(idx) + 4'd1;

endmodule

// File: tb/tb_player_ctl_nsong.sv
// Bench for player_ctl_nsong: vector table on a 4-song build, plus
// corner sequences and a 5-song build for non-power-of-two wrap.
module tb_player_ctl_nsong;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  player_ctl_nsong_if #(.NUM_SONGS(4), .PIX_W(16)) b4 ();
  player_ctl_nsong_if #(.NUM_SONGS(5), .PIX_W(16)) b5 ();

  player_ctl_nsong #(
    .NUM_SONGS(4), .SEL_W(2), .PIX_W(16)
  ) u4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave)
  );

  player_ctl_nsong #(
    .NUM_SONGS(5), .SEL_W(3), .PIX_W(16)
  ) u5 (
    .clk(clk), .rst_n(rst_n), .bus(b5.slave)
  );

  typedef struct {
    logic       st, sp, nx, pr;
    logic [3:0] dn;
    logic [3:0] en, rs;
    logic       ss;
    logic [3:0] hx;
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(
    logic st, logic sp, logic nx, logic pr, logic [3:0] dn,
    logic [3:0] en, logic [3:0] rs, logic ss, logic [3:0] hx);
    vec_t v;
    v.st = st; v.sp = sp; v.nx = nx; v.pr = pr; v.dn = dn;
    v.en = en; v.rs = rs; v.ss = ss; v.hx = hx;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic keys4(logic st, logic sp, logic nx, logic pr);
    b4.start = st; b4.stop = sp;
    b4.next_song = nx; b4.pre_song = pr;
  endtask

  function automatic logic [15:0] pix(int k);
    return 16'hA000 + 16'(k);
  endfunction

  int nrs;

  initial begin
    keys4(0, 0, 0, 0);
    b4.song_done = '0;
    b4.frq_in    = 4'b0110;
    for (int k = 0; k < 4; k++)
      b4.pixel_data[k*16 +: 16] = pix(k);
    b5.start = 0; b5.stop = 0;
    b5.next_song = 0; b5.pre_song = 0;
    b5.song_done = '0;
    b5.frq_in    = '0;
    b5.pixel_data = '0;

    //       st sp nx pr dn    en  rs  ss hx
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0, 0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,0,1,1));
    tbl.push_back(mk(0,0,1,0,0, 0,2,1,2));
    tbl.push_back(mk(0,0,0,0,0, 2,0,0,2));
    tbl.push_back(mk(0,0,1,0,0, 0,4,1,3));
    tbl.push_back(mk(0,0,0,0,0, 4,0,0,3));
    tbl.push_back(mk(0,0,1,0,0, 0,8,1,4));
    tbl.push_back(mk(0,0,0,0,0, 8,0,0,4));
    tbl.push_back(mk(0,0,1,0,0, 0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,1));
    tbl.push_back(mk(0,0,0,1,0, 0,8,1,4));
    tbl.push_back(mk(0,0,0,0,0, 8,0,0,4));
    tbl.push_back(mk(0,0,0,0,0, 8,0,1,4));
    tbl.push_back(mk(0,1,0,0,0, 0,0,1,4));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,4));
    tbl.push_back(mk(1,0,0,0,0, 8,0,0,4));
    tbl.push_back(mk(1,0,0,0,0, 8,0,1,4));
    tbl.push_back(mk(0,1,0,0,0, 0,0,1,4));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,4));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,4));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,4));
    tbl.push_back(mk(0,0,1,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(1,0,0,0,0, 0,1,0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,1));
    tbl.push_back(mk(0,1,1,0,0, 0,0,1,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1));
    tbl.push_back(mk(0,0,0,1,0, 0,0,0,4));
    tbl.push_back(mk(1,0,1,0,0, 0,8,0,4));
    tbl.push_back(mk(0,0,0,0,0, 8,0,0,4));
`ifdef AUTO_ADVANCE_EN
    tbl.push_back(mk(0,0,0,0,8, 0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0,1));
`else
    tbl.push_back(mk(0,0,0,0,8, 0,0,1,4));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,4));
`endif

    tick();
    tick();
    chk("rst_en", 32'(b4.song_en), 0);
    chk("rst_restart", 32'(b4.song_restart), 0);
    chk("rst_frq", 32'(b4.frq), 0);
    chk("rst_pix", 32'(b4.o_pixel_data), 0);
    chk("rst_ss", 32'(b4.start_stop), 0);
    chk("rst_hex", 32'(b4.o_hex_data), 1);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      keys4(tbl[i].st, tbl[i].sp, tbl[i].nx, tbl[i].pr);
      b4.song_done = tbl[i].dn;
      tick();
      chk($sformatf("v%0d_en", i), 32'(b4.song_en), 32'(tbl[i].en));
      chk($sformatf("v%0d_rs", i), 32'(b4.song_restart),
          32'(tbl[i].rs));
      chk($sformatf("v%0d_ss", i), 32'(b4.start_stop),
          32'(tbl[i].ss));
      chk($sformatf("v%0d_hex", i), 32'(b4.o_hex_data),
          32'(tbl[i].hx));
    end
    keys4(0, 0, 0, 0);
    b4.song_done = '0;

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Held start key: exactly one restart strobe.
    nrs = 0;
    b4.start = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (b4.song_restart != 0) nrs++;
    end
    b4.start = 1'b0;
    chk("hold_start_strobes", 32'(nrs), 1);
    chk("hold_start_en", 32'(b4.song_en), 1);
    chk("hold_start_ss", 32'(b4.start_stop), 1);

    b4.song_done = 4'b0010;
    tick();
    chk("done_other_en", 32'(b4.song_en), 1);
    b4.song_done = '0;
    tick();
    chk("done_other_rs", 32'(b4.song_restart), 0);

    b4.song_done = 4'b0001;
    b4.next_song = 1'b1;
    tick();
    chk("done_vs_key_rs", 32'(b4.song_restart), 2);
    chk("done_vs_key_hex", 32'(b4.o_hex_data), 2);
    b4.song_done = '0;
    b4.next_song = 1'b0;
    tick();
    chk("done_vs_key_en", 32'(b4.song_en), 2);
    tick();
    chk("play_frq", 32'(b4.frq), 1);
    chk("play_pix", 32'(b4.o_pixel_data), 32'(pix(1)));

    b4.stop = 1'b1;
    tick();
    b4.stop = 1'b0;
    tick();
    chk("pause_frq", 32'(b4.frq), 0);
    chk("pause_en", 32'(b4.song_en), 0);
    b4.pixel_data[16 +: 16] = 16'h5A5A;
    tick();
    chk("pause_pix_live", 32'(b4.o_pixel_data), 32'h5A5A);
    b4.start = 1'b1;
    tick();
    chk("resume_en", 32'(b4.song_en), 2);
    chk("resume_rs", 32'(b4.song_restart), 0);
    b4.start = 1'b0;
    tick();
    tick();
    chk("resume_frq", 32'(b4.frq), 1);

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_en", 32'(b4.song_en), 0);
    chk("async_frq", 32'(b4.frq), 0);
    chk("async_pix", 32'(b4.o_pixel_data), 0);
    chk("async_ss", 32'(b4.start_stop), 0);
    chk("async_hex", 32'(b4.o_hex_data), 1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("post_rst_en", 32'(b4.song_en), 0);
    chk("post_rst_rs", 32'(b4.song_restart), 0);

    b5.pre_song = 1'b1;
    tick();
    chk("n5_pre_wrap", 32'(b5.o_hex_data), 5);
    b5.pre_song = 1'b0;
    tick();
    b5.pre_song = 1'b1;
    tick();
    chk("n5_pre_dec", 32'(b5.o_hex_data), 4);
    b5.pre_song = 1'b0;
    tick();
    b5.next_song = 1'b1;
    tick();
    b5.next_song = 1'b0;
    tick();
    b5.next_song = 1'b1;
    tick();
    chk("n5_next_wrap", 32'(b5.o_hex_data), 1);
    b5.next_song = 1'b0;
    chk("n5_no_strobe", 32'(b5.song_restart), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
